// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcodes and the select codes the controller drives into the datapath.
package mips_ctrl_pkg;

    // Codes 12..15 are unused and recover to ST_FETCH.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath (Moore, three processes).
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on the mem_ready handshake.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic               iord,
    output logic               mem_we,
    output logic               mem_re,
    output logic               ir_we,
    output logic               mdr_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_we,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] busy_state
);

    state_t     state, state_nxt;
    logic       mem_ok;
    logic [1:0] alu_op_d;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = ST_FETCH;
        unique case (state)
            ST_FETCH:    state_nxt = mem_ok ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = ST_MEMADR;
                    OP_RTYPE:     state_nxt = ST_EXECUTE;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_ADDI:      state_nxt = ST_ADDIEXEC;
                    OP_J:         state_nxt = ST_JUMP;
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OP_LW)      state_nxt = ST_MEMREAD;
                else if (opcode == OP_SW) state_nxt = ST_MEMWRITE;
                else                      state_nxt = ST_FETCH;
            end
            ST_MEMREAD:  state_nxt = mem_ok ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWRITE: state_nxt = mem_ok ? ST_FETCH : ST_MEMWRITE;
            ST_EXECUTE:  state_nxt = ST_ALUWB;
            ST_ADDIEXEC: state_nxt = ST_ADDIWB;
            default:     state_nxt = ST_FETCH;
        endcase
    end

    // The async reset parks the state in FETCH, so outputs are gated by rst
    // as well; otherwise FETCH's enables would be live during reset.
    always_comb begin
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op_d   = ALU_ADD;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_re    = 1'b1;
                    ir_we     = mem_ok;
                    pc_we     = mem_ok;
                    alu_src_b = SRCB_FOUR;
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                ST_MEMADR, ST_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEMREAD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                    mdr_we = mem_ok;
                end
                ST_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_we     = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_we = mem_ok;
                    iord   = 1'b1;
                end
                ST_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op_d  = ALU_FUNCT;
                end
                ST_ALUWB: begin
                    reg_dst = 1'b1;
                    reg_we  = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op_d  = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_we     = zero;
                end
                ST_ADDIWB: reg_we = 1'b1;
                ST_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_op     = ALUOP_W'(alu_op_d);
    assign busy_state = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, iord, mem_we, mem_re, ir_we, mdr_we;
    logic       reg_dst, mem_to_reg, reg_we, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] busy_state;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, iord, mem_we, mem_re, ir_we, mdr_we;
        logic       reg_dst, mem_to_reg, reg_we, alu_src_a;
        logic [1:0] src_b, alu_op, pc_src;
        logic       illegal;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  mon_exp, mon_act;
    string mon_name;
    int    total = 0;
    int    bad   = 0;

    multicycle_ctrl #(.STATE_W(4), .ALUOP_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .iord(iord), .mem_we(mem_we), .mem_re(mem_re), .ir_we(ir_we),
        .mdr_we(mdr_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .illegal_op(illegal_op), .busy_state(busy_state)
    );

    always #5 clk = ~clk;

    // Expected outputs per state, written out from the control table.
    function automatic obs_t model(input state_t s, input logic z, input logic ill, input logic rdy);
        obs_t o;
        o    = '0;
        o.st = s;
        case (s)
            ST_FETCH:    begin o.mem_re = 1; o.ir_we = rdy; o.pc_we = rdy; o.src_b = 2'b01; end
            ST_DECODE:   begin o.src_b = 2'b11; o.illegal = ill; end
            ST_MEMADR:   begin o.alu_src_a = 1; o.src_b = 2'b10; end
            ST_MEMREAD:  begin o.mem_re = 1; o.iord = 1; o.mdr_we = rdy; end
            ST_MEMWB:    begin o.mem_to_reg = 1; o.reg_we = 1; end
            ST_MEMWRITE: begin o.mem_we = rdy; o.iord = 1; end
            ST_EXECUTE:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            ST_ALUWB:    begin o.reg_dst = 1; o.reg_we = 1; end
            ST_BRANCH:   begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_we = z; end
            ST_ADDIEXEC: begin o.alu_src_a = 1; o.src_b = 2'b10; end
            ST_ADDIWB:   begin o.reg_we = 1; end
            ST_JUMP:     begin o.pc_src = 2'b10; o.pc_we = 1; end
            default:     ;
        endcase
        return o;
    endfunction

    // Called at posedge+1: queues this cycle's expectation, then advances one clock.
    task automatic step(input state_t s, input string nm, input logic ill, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(model(s, zero, ill, rdy));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic step_rst(input string nm);
        obs_t o;
        o    = '0;
        o.st = ST_FETCH;
        exp_q.push_back(o);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {busy_state, pc_we, iord, mem_we, mem_re, ir_we, mdr_we,
                        reg_dst, mem_to_reg, reg_we, alu_src_a, alu_src_b, alu_op,
                        pc_src, illegal_op};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        opcode    = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step_rst("in_reset");
        rst = 1'b0;

        // lw, with a junk opcode once MEMADR has already decided the path
        opcode = OP_LW;
        step(ST_FETCH,   "lw_fetch",   1'b0, 1'b1);
        step(ST_DECODE,  "lw_decode",  1'b0, 1'b1);
        step(ST_MEMADR,  "lw_memadr",  1'b0, 1'b1);
        opcode = 6'b111111;
        step(ST_MEMREAD, "lw_memread", 1'b0, 1'b1);
        step(ST_MEMWB,   "lw_memwb",   1'b0, 1'b1);

        opcode = OP_SW;
        step(ST_FETCH,    "sw_fetch",    1'b0, 1'b1);
        step(ST_DECODE,   "sw_decode",   1'b0, 1'b1);
        step(ST_MEMADR,   "sw_memadr",   1'b0, 1'b1);
        step(ST_MEMWRITE, "sw_memwrite", 1'b0, 1'b1);

        opcode = OP_RTYPE;
        step(ST_FETCH,   "r_fetch",   1'b0, 1'b1);
        step(ST_DECODE,  "r_decode",  1'b0, 1'b1);
        step(ST_EXECUTE, "r_execute", 1'b0, 1'b1);
        step(ST_ALUWB,   "r_aluwb",   1'b0, 1'b1);

        opcode = OP_ADDI;
        step(ST_FETCH,    "addi_fetch",  1'b0, 1'b1);
        step(ST_DECODE,   "addi_decode", 1'b0, 1'b1);
        step(ST_ADDIEXEC, "addi_exec",   1'b0, 1'b1);
        step(ST_ADDIWB,   "addi_wb",     1'b0, 1'b1);

        opcode = OP_BEQ;
        zero   = 1'b1;
        step(ST_FETCH,  "beq_taken_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "beq_taken_decode", 1'b0, 1'b1);
        step(ST_BRANCH, "beq_taken_branch", 1'b0, 1'b1);
        zero   = 1'b0;
        step(ST_FETCH,  "beq_nt_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "beq_nt_decode", 1'b0, 1'b1);
        step(ST_BRANCH, "beq_nt_branch", 1'b0, 1'b1);

        opcode = OP_J;
        step(ST_FETCH,  "j_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "j_decode", 1'b0, 1'b1);
        step(ST_JUMP,   "j_jump",   1'b0, 1'b1);

        opcode = 6'b111111;
        step(ST_FETCH,  "ill3f_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "ill3f_decode", 1'b1, 1'b1);
        opcode = 6'b000001;
        step(ST_FETCH,  "ill01_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "ill01_decode", 1'b1, 1'b1);

        // Reset lands at the start of MEMWRITE: state and mem_we drop at once
        opcode = OP_SW;
        step(ST_FETCH,  "swrst_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "swrst_decode", 1'b0, 1'b1);
        step(ST_MEMADR, "swrst_memadr", 1'b0, 1'b1);
        rst = 1'b1;
        step_rst("swrst_in_memwrite");
        step_rst("swrst_held");
        rst = 1'b0;
        opcode = OP_J;
        step(ST_FETCH,  "post_rst_fetch",  1'b0, 1'b1);
        step(ST_DECODE, "post_rst_decode", 1'b0, 1'b1);
        step(ST_JUMP,   "post_rst_jump",   1'b0, 1'b1);

`ifdef MEM_WAIT_EN
        opcode = OP_LW;
        step(ST_FETCH,   "wlw_fetch",  1'b0, 1'b1);
        step(ST_DECODE,  "wlw_decode", 1'b0, 1'b1);
        step(ST_MEMADR,  "wlw_memadr", 1'b0, 1'b1);
        repeat (3) step(ST_MEMREAD, "wlw_stall", 1'b0, 1'b0);
        step(ST_MEMREAD, "wlw_memread", 1'b0, 1'b1);
        step(ST_MEMWB,   "wlw_memwb",   1'b0, 1'b1);
        step(ST_FETCH,   "wlw_next_fetch", 1'b0, 1'b1);
`endif

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
